// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: fetch FSM state encoding, the canonical NOP
// and the sequential PC step.
package rv32_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] PC_INCREMENT = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the external instruction memory
// address and presents one registered instruction to decode with a valid/ready handshake.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] inst_in,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        misaligned_err,
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         load;
    logic         redirect_taken;
    logic         redirect_misaligned;

    // The memory address comes straight from the PC register, so the
    // memory -> inst_in path never sees handshake or redirect timing.
    assign pc_out = pc;

    assign load                = (state == RUN) && (!if_valid || if_ready) && !redirect_valid;
    assign redirect_taken      = redirect_valid && (state != HALTED);
    assign redirect_misaligned = (redirect_target[1:0] != 2'b00);

    // NOTE: all state here is registered with non-blocking assignments so every
    // branch reads the pre-edge values of state, pc and if_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_VECTOR;
            if_inst        <= NOP_INST;
            if_pc          <= 32'h0000_0000;
            if_valid       <= 1'b0;
            misaligned_err <= 1'b0;
            halted         <= 1'b0;
        end else if (redirect_taken) begin
            // A redirect flushes the staged instruction and beats any load.
            if_valid <= 1'b0;
            if (redirect_misaligned) begin
                misaligned_err <= 1'b1;
                state          <= HALTED;
                halted         <= 1'b1;
            end else begin
                pc <= redirect_target;
                if (state == RUN && halt_req) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end
        end else begin
            if (load) begin
                if_inst  <= inst_in;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + PC_INCREMENT;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end

            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (halt_req) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    // A misaligned-target halt can only be left through reset.
                    if (resume && !misaligned_err && !halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level fetch model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;

    logic [31:0] pc_out,  inst_in,  if_inst,  if_pc;
    logic        if_valid, misaligned_err, halted;
    logic [31:0] pc_out2, inst_in2, if_inst2, if_pc2;
    logic        if_valid2, misaligned_err2, halted2;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]};
    endfunction

    assign inst_in  = mem_word(pc_out);
    assign inst_in2 = mem_word(pc_out2);

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .inst_in(inst_in),
        .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .resume(resume),
        .misaligned_err(misaligned_err), .halted(halted)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .pc_out(pc_out2), .inst_in(inst_in2),
        .if_inst(if_inst2), .if_pc(if_pc2), .if_valid(if_valid2), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .resume(resume),
        .misaligned_err(misaligned_err2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // booted: the one-cycle start-up slot has passed; stopped: fetching halted.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] ipc;
        bit          valid;
        bit          booted;
        bit          stopped;
        bit          err;
    } model_t;

    model_t m1, m2;

    function automatic model_t model_reset(input logic [31:0] vec);
        model_t m;
        m.pc = vec; m.inst = 32'h0000_0013; m.ipc = 32'h0; m.valid = 1'b0;
        m.booted = 1'b0; m.stopped = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input bit rdy, input bit rv,
                                          input logic [31:0] tgt, input bit hreq, input bit res);
        model_t n = m;
        bit running = m.booted && !m.stopped;
        bit fetch   = running && (!m.valid || rdy) && !rv;
        if (rv && !m.stopped) begin
            n.valid  = 1'b0;
            n.booted = 1'b1;
            if (tgt[1:0] != 2'b00) begin
                n.err     = 1'b1;
                n.stopped = 1'b1;
            end else begin
                n.pc = tgt;
                if (running && hreq) n.stopped = 1'b1;
            end
        end else begin
            if (fetch) begin
                n.inst  = mem_word(m.pc);
                n.ipc   = m.pc;
                n.valid = 1'b1;
                n.pc    = m.pc + 32'd4;
            end else if (m.valid && rdy) begin
                n.valid = 1'b0;
            end
            if (!m.booted)                                   n.booted  = 1'b1;
            else if (running && hreq)                        n.stopped = 1'b1;
            else if (m.stopped && res && !m.err && !hreq)    n.stopped = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1 = model_reset(32'h0000_0000);
            m2 = model_reset(32'hFFFF_FFFC);
        end else begin
            m1 = model_step(m1, if_ready, redirect_valid, redirect_target, halt_req, resume);
            m2 = model_step(m2, if_ready, redirect_valid, redirect_target, halt_req, resume);
        end
    end

    task automatic compare(input string tag, input model_t m, input logic [31:0] a_pc,
                           input logic a_valid, input logic [31:0] a_ipc, input logic [31:0] a_inst,
                           input logic a_err, input logic a_halted);
        check({tag, ".pc_out"},   a_pc,             m.pc);
        check({tag, ".if_valid"}, {31'b0, a_valid}, {31'b0, m.valid});
        check({tag, ".if_pc"},    a_ipc,            m.ipc);
        check({tag, ".if_inst"},  a_inst,           m.inst);
        check({tag, ".err"},      {31'b0, a_err},   {31'b0, m.err});
        check({tag, ".halted"},   {31'b0, a_halted},{31'b0, m.stopped});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            compare("model0", m1, pc_out, if_valid, if_pc, if_inst, misaligned_err, halted);
            compare("modelW", m2, pc_out2, if_valid2, if_pc2, if_inst2, misaligned_err2, halted2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'h0; halt_req = 1'b0; resume = 1'b0;
        #1 reset = 1'b1;
        tick(); tick();
        check("rst.pc_out",   pc_out,  32'h0);
        check("rst.if_valid", {31'b0, if_valid}, 32'h0);
        check("rst.if_inst",  if_inst, 32'h0000_0013);
        check("rst.if_pc",    if_pc,   32'h0);
        check("rst.halted",   {31'b0, halted}, 32'h0);
        check("rst.err",      {31'b0, misaligned_err}, 32'h0);
        check("rst.pc_out_wrapvec", pc_out2, 32'hFFFF_FFFC);
        reset = 1'b0;

        // Boot cycle, then sequential fetch 0, 4, 8.
        tick();
        check("boot.pc_out",   pc_out, 32'h0);
        check("boot.if_valid", {31'b0, if_valid}, 32'h0);
        tick();
        check("seq.if_pc0",   if_pc,   32'h0);
        check("seq.if_inst0", if_inst, mem_word(32'h0));
        check("wrap.if_pc0",  if_pc2,  32'hFFFF_FFFC);
        tick();
        check("seq.if_pc4",   if_pc,   32'h4);
        check("seq.if_inst1", if_inst, mem_word(32'h4));
        check("wrap.if_pc1",  if_pc2,  32'h0);
        tick();
        check("seq.if_pc8",   if_pc,   32'h8);
        check("seq.if_inst2", if_inst, mem_word(32'h8));

        // Backpressure: three stalled cycles.
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.if_pc",   if_pc,   32'h8);
            check("stall.if_inst", if_inst, mem_word(32'h8));
            check("stall.pc_out",  pc_out,  32'hC);
        end
        if_ready = 1'b1;
        tick();
        check("stall.release_if_pc", if_pc, 32'hC);

        // Aligned redirect at pc_out 0x20.
        for (int i = 0; i < 20 && pc_out != 32'h20; i++) tick();
        check("redir.reach_0x20", pc_out, 32'h20);
        redirect_valid = 1'b1; redirect_target = 32'h14;
        tick();
        redirect_valid = 1'b0;
        check("redir.if_valid", {31'b0, if_valid}, 32'h0);
        check("redir.pc_out",   pc_out, 32'h14);
        tick();
        check("redir.if_pc",    if_pc, 32'h14);

        // One-cycle halt request, then resume with no skipped or repeated PC.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt.halted",  {31'b0, halted}, 32'h1);
        check("halt.if_pc",   if_pc, 32'h18);
        tick(); tick();
        check("halt.if_valid", {31'b0, if_valid}, 32'h0);
        check("halt.pc_out",   pc_out, 32'h1C);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume.halted", {31'b0, halted}, 32'h0);
        tick();
        check("resume.if_pc",  if_pc, 32'h1C);

        // Misaligned redirect: sticky error, halt, pc unchanged, resume ignored.
        redirect_valid = 1'b1; redirect_target = 32'h22;
        tick();
        redirect_valid = 1'b0;
        check("mis.err",    {31'b0, misaligned_err}, 32'h1);
        check("mis.halted", {31'b0, halted}, 32'h1);
        check("mis.pc_out", pc_out, 32'h20);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("mis.still_halted", {31'b0, halted}, 32'h1);
        check("mis.pc_ignored",   pc_out, 32'h20);
        tick();

        // Asynchronous reset mid-stream with a redirect pending.
        #2;
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
        #1;
        check("arst.pc_out", pc_out, 32'h0);
        check("arst.err",    {31'b0, misaligned_err}, 32'h0);
        check("arst.halted", {31'b0, halted}, 32'h0);
        check("arst.valid",  {31'b0, if_valid}, 32'h0);
        tick();
        reset = 1'b0; redirect_valid = 1'b0;
        tick();
        check("restart.pc_out", pc_out, 32'h0);
        tick();
        check("restart.if_pc",  if_pc,  32'h0);
        check("restart.wrap_if_pc", if_pc2, 32'hFFFF_FFFC);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset; bits [1:0] are zero.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc_out  output  32  current fetch address, driven combinationally to the instruction memory address input.
REQ-005 SHALL have port inst_in  input  32  instruction word returned combinationally by instruction memory for pc_out.
REQ-006 SHALL have port if_inst  output  32  registered instruction presented to decode.
REQ-007 SHALL have port if_pc  output  32  registered address of if_inst.
REQ-008 SHALL have port if_valid  output  1  if_inst/if_pc hold a valid instruction.
REQ-009 SHALL have port if_ready  input  1  decode accepts the current instruction this cycle.
REQ-010 SHALL have port redirect_valid  input  1  taken branch/jump this cycle.
REQ-011 SHALL have port redirect_target  input  32  new fetch address when redirect_valid=1.
REQ-012 SHALL have port halt_req  input  1  request to stop fetching.
REQ-013 SHALL have port resume  input  1  pulse to leave HALTED.
REQ-014 SHALL have port misaligned_err  output  1  sticky flag: redirect target had bits [1:0] != 0.
REQ-015 SHALL have port halted  output  1  high while FSM is in HALTED.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HALTED; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-017 SHALL drive pc_out from the PC register with zero combinational dependence on if_ready or redirect inputs.
REQ-018 SHALL define load = (state==RUN) && (!if_valid || if_ready) && !redirect_valid.
REQ-019 SHALL on load capture if_inst<=inst_in, if_pc<=pc, if_valid<=1, pc<=pc+4 (modulo 2^32; 0xFFFF_FFFC wraps to 0).
REQ-020 SHALL when (if_valid && !if_ready && no redirect) hold pc, if_inst, if_pc, if_valid unchanged.
REQ-021 SHALL when if_valid && if_ready && !load (BOOT/HALTED) clear if_valid next cycle.
REQ-022 SHALL on redirect_valid with aligned target in BOOT or RUN set pc<=redirect_target and if_valid<=0 next cycle (flush; redirect beats load); first post-redirect instruction appears on if_* two edges after the redirect cycle.
REQ-023 SHALL on redirect_valid with redirect_target[1:0]!=0 leave pc unchanged, clear if_valid, set misaligned_err<=1, go to HALTED.
REQ-024 SHALL ignore redirect_valid while in HALTED.
REQ-025 SHALL on halt_req in RUN go to HALTED next cycle; a load in the same cycle still completes; simultaneous aligned redirect updates pc then halts.
REQ-026 SHALL in HALTED perform no loads; an already-valid if_* entry remains until handshaken.
REQ-027 SHALL on resume in HALTED go to RUN next cycle only if misaligned_err=0 and halt_req=0; otherwise stay HALTED.
REQ-028 SHALL keep misaligned_err set until reset.

Reset
REQ-029 SHALL on reset assertion immediately force pc=RESET_VECTOR, if_inst=32'h0000_0013 (nop), if_pc=0, if_valid=0, misaligned_err=0, halted=0, state=BOOT.
REQ-030 SHALL on reset asserted mid-stream discard any pending instruction and redirect; fetch restarts at RESET_VECTOR.

Structure
REQ-031 SHALL place FSM state encoding, NOP encoding (32'h0000_0013) and PC increment (4) in shared package rv32_pkg.
REQ-032 SHALL be a single module with no sub-modules; instruction memory stays external.

Verification
REQ-033 SHALL check: reset, release, if_ready=1 -> pc_out 0 (BOOT), then if_pc 0,4,8 on consecutive cycles with if_inst=memory words 0,1,2.
REQ-034 SHALL check: if_ready=0 for 3 cycles with if_pc=0x8 -> if_pc, if_inst, pc_out (0xC) stable; if_ready=1 -> if_pc 0xC next.
REQ-035 SHALL check: redirect_valid=1, target 0x14, at pc_out 0x20 -> if_valid=0 next cycle, pc_out=0x14, then if_pc=0x14.
REQ-036 SHALL check: redirect target 0x22 -> misaligned_err=1, halted=1, pc_out unchanged; resume ignored until reset.
REQ-037 SHALL check: RESET_VECTOR=0xFFFF_FFFC -> if_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-038 SHALL check: halt_req one cycle -> no further loads, halted=1; resume -> fetch continues at held pc with no skipped or duplicated if_pc.
